// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and 7-segment helpers for the mm:ss stopwatch.
//   state_t   : controller states IDLE / RUN / PAUSE / DONE
//   bcd_t     : one BCD digit
//   SEG_*     : active-low segment patterns {g,f,e,d,c,b,a}
//   seg7()    : digit to pattern, SEG_BLANK for non-decimal codes
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] seg7(input bcd_t v);
      case (v)
         4'd0:    seg7 = SEG_0;
         4'd1:    seg7 = SEG_1;
         4'd2:    seg7 = SEG_2;
         4'd3:    seg7 = SEG_3;
         4'd4:    seg7 = SEG_4;
         4'd5:    seg7 = SEG_5;
         4'd6:    seg7 = SEG_6;
         4'd7:    seg7 = SEG_7;
         4'd8:    seg7 = SEG_8;
         4'd9:    seg7 = SEG_9;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/stopwatch_timer_ctrl_key_debounce.sv
// key_debounce: 2-FF synchroniser plus stability counter for one raw key.
//   clock   : system clock
//   reset_n : asynchronous active-low reset (key reads released)
//   key_n   : raw key, active low
//   press   : one-cycle pulse when a press (1->0) has been stable DBNC_CYC cycles
module key_debounce #(
   parameter int unsigned DBNC_CYC = 1_000_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic key_n,
   output logic press
);
   import stopwatch_pkg::*;

   localparam int unsigned CW = $clog2(DBNC_CYC + 1);

   logic          sync1, sync2, stable;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         stable <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DBNC_CYC - 1)) begin
            // Level has differed for DBNC_CYC cycles: accept it; only a
            // falling edge produces a pulse.
            stable <= sync2;
            cnt    <= '0;
            press  <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_timer_ctrl.sv
// stopwatch_timer_ctrl: mm:ss stopwatch / countdown timer driving 4 x 7-seg.
//   clock, reset_n           : clock, asynchronous active-low reset
//   start_key_n, clear_key_n : raw keys (run/pause toggle, clear)
//   lap_key_n                : raw lap-hold key, only active with LAP_HOLD_EN
//   mode_down                : count direction, latched when leaving IDLE
//   load, preset_bcd         : one-cycle load of a clamped BCD preset
//   time_bcd                 : displayed count {min_t,min_u,sec_t,sec_u}
//   hex3..hex0               : registered active-low segments, hex3 = min tens
//   running, expired, wrap   : in RUN, in DONE, up-count wrap pulse
// Optional feature macro: LAP_HOLD_EN (lap freeze of display while counting).
module stopwatch_timer_ctrl #(
   parameter int unsigned DIV      = 50_000_000,
   parameter int unsigned DBNC_CYC = 1_000_000,
   parameter int unsigned MAX_MIN  = 59
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start_key_n,
   input  logic        clear_key_n,
   input  logic        lap_key_n,
   input  logic        mode_down,
   input  logic        load,
   input  logic [15:0] preset_bcd,
   output logic [15:0] time_bcd,
   output logic [6:0]  hex3,
   output logic [6:0]  hex2,
   output logic [6:0]  hex1,
   output logic [6:0]  hex0,
   output logic        running,
   output logic        expired,
   output logic        wrap
);
   import stopwatch_pkg::*;

   localparam int unsigned     PW      = $clog2(DIV);
   localparam logic [PW-1:0]   PRE_TOP = PW'(DIV - 1);
   localparam bcd_t            MAX_T   = bcd_t'(MAX_MIN / 10);
   localparam bcd_t            MAX_U   = bcd_t'(MAX_MIN % 10);
   localparam logic [15:0]     TOP_BCD = {MAX_T, MAX_U, 4'd5, 4'd9};

   function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
      bcd_t mt, mu, st, su;
      mt = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
      mu = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
      st = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
      su = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
      if ((mt > MAX_T) || ((mt == MAX_T) && (mu > MAX_U)))
         clamp_bcd = TOP_BCD;
      else
         clamp_bcd = {mt, mu, st, su};
   endfunction

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      bcd_t mt, mu, st, su;
      {mt, mu, st, su} = v;
      if (su != 4'd9) su = su + 4'd1;
      else begin
         su = '0;
         if (st != 4'd5) st = st + 4'd1;
         else begin
            st = '0;
            if (mu != 4'd9) mu = mu + 4'd1;
            else begin
               mu = '0;
               mt = mt + 4'd1;
            end
         end
      end
      bcd_inc = {mt, mu, st, su};
   endfunction

   // Saturates at 00:00 so a zero count resumed from PAUSE simply expires.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      bcd_t mt, mu, st, su;
      {mt, mu, st, su} = v;
      if (v != '0) begin
         if (su != 4'd0) su = su - 4'd1;
         else begin
            su = 4'd9;
            if (st != 4'd0) st = st - 4'd1;
            else begin
               st = 4'd5;
               if (mu != 4'd0) mu = mu - 4'd1;
               else begin
                  mu = 4'd9;
                  mt = mt - 4'd1;
               end
            end
         end
      end
      bcd_dec = {mt, mu, st, su};
   endfunction

   state_t        state, next_state;
   logic [PW-1:0] pre;
   logic [15:0]   time_q, time_step, lap_val, disp;
   logic          dir, lap_hold, lap_toggle;
   logic          start_p, clear_p, lap_p;
   logic          load_acc, tick, at_max;

   key_debounce #(.DBNC_CYC(DBNC_CYC)) u_start (
      .clock(clock), .reset_n(reset_n), .key_n(start_key_n), .press(start_p));
   key_debounce #(.DBNC_CYC(DBNC_CYC)) u_clear (
      .clock(clock), .reset_n(reset_n), .key_n(clear_key_n), .press(clear_p));
   key_debounce #(.DBNC_CYC(DBNC_CYC)) u_lap (
      .clock(clock), .reset_n(reset_n), .key_n(lap_key_n), .press(lap_p));

   // Priority clear > load > start > tick is folded into these qualifiers.
   assign load_acc = load && (state != RUN);
   assign tick     = (state == RUN) && (pre == PRE_TOP) && !clear_p && !start_p;
   assign at_max   = (time_q == TOP_BCD);

   always_comb begin
      if (dir)         time_step = bcd_dec(time_q);
      else if (at_max) time_step = '0;
      else             time_step = bcd_inc(time_q);
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      if (clear_p) begin
         next_state = IDLE;
      end else if (load_acc) begin
         if (state == DONE) next_state = IDLE;
      end else begin
         unique case (state)
            IDLE:  if (start_p && !(mode_down && (time_q == '0))) next_state = RUN;
            RUN:   if (start_p) next_state = PAUSE;
                   else if (tick && dir && (time_step == '0)) next_state = DONE;
            PAUSE: if (start_p) next_state = RUN;
            DONE:  next_state = DONE;
         endcase
      end
   end

   // Output logic
   always_comb begin
      running = (state == RUN);
      expired = (state == DONE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         time_q <= '0;
         pre    <= '0;
         dir    <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clear_p) begin
            time_q <= '0;
            pre    <= '0;
         end else if (load_acc) begin
            time_q <= clamp_bcd(preset_bcd);
         end else if (tick) begin
            time_q <= time_step;
            pre    <= '0;
            wrap   <= !dir && at_max;
         end else if ((state == RUN) && !start_p) begin
            pre <= pre + 1'b1;
         end
         if ((state == IDLE) && (next_state == RUN)) begin
            dir <= mode_down;
            pre <= '0;
         end
      end
   end

`ifdef LAP_HOLD_EN
   assign lap_toggle = lap_p;
`else
   // Lap key stays debounced but cannot set the hold flag.
   assign lap_toggle = lap_p & lap_hold;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lap_hold <= 1'b0;
         lap_val  <= '0;
      end else if (state != RUN) begin
         lap_hold <= 1'b0;
      end else if (lap_toggle) begin
         lap_hold <= !lap_hold;
         lap_val  <= time_q;
      end
   end

   assign disp     = lap_hold ? lap_val : time_q;
   assign time_bcd = disp;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hex3 <= SEG_0;
         hex2 <= SEG_0;
         hex1 <= SEG_0;
         hex0 <= SEG_0;
      end else begin
         hex3 <= seg7(disp[15:12]);
         hex2 <= seg7(disp[11:8]);
         hex1 <= seg7(disp[7:4]);
         hex0 <= seg7(disp[3:0]);
      end
   end

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_timer_ctrl;

   localparam int DIV  = 4;
   localparam int DBNC = 2;
   localparam int MAXM = 59;
   localparam int LAT  = 3 + DBNC;   // edges from key drive to the edge acting on the press

`ifdef LAP_HOLD_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_key_n = 1'b1, clear_key_n = 1'b1, lap_key_n = 1'b1;
   logic        mode_down = 1'b0, load = 1'b0;
   logic [15:0] preset_bcd = '0;
   logic [15:0] time_bcd;
   logic [6:0]  hex3, hex2, hex1, hex0;
   logic        running, expired, wrap;

   stopwatch_timer_ctrl #(.DIV(DIV), .DBNC_CYC(DBNC), .MAX_MIN(MAXM)) dut (
      .clock(clock), .reset_n(reset_n),
      .start_key_n(start_key_n), .clear_key_n(clear_key_n), .lap_key_n(lap_key_n),
      .mode_down(mode_down), .load(load), .preset_bcd(preset_bcd),
      .time_bcd(time_bcd), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
      .running(running), .expired(expired), .wrap(wrap));

   always #5 clock = ~clock;

   typedef struct packed {
      logic [15:0] t;
      logic [27:0] hex;
      logic        run;
      logic        exp;
      logic        wr;
   } obs_t;

   typedef struct {
      int   cyc;
      obs_t o;
   } ev_t;

   ev_t  sb[$];
   int   start_q[$], clear_q[$], lap_q[$];
   int   checks = 0, errors = 0, cyc = 0;
   bit   mon_en = 1'b0;
   obs_t m_prev, d_prev;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;  default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [15:0] to_bcd(input int s);
      int m, r;
      logic [3:0] a, b, c, d;
      m = s / 60;
      r = s % 60;
      a = 4'(m / 10);
      b = 4'(m % 10);
      c = 4'(r / 10);
      d = 4'(r % 10);
      return {a, b, c, d};
   endfunction

   function automatic int clamp_secs(input logic [15:0] v);
      int mt, mu, st, su, m;
      mt = (int'(v[15:12]) > 9) ? 9 : int'(v[15:12]);
      mu = (int'(v[11:8])  > 9) ? 9 : int'(v[11:8]);
      st = (int'(v[7:4])   > 5) ? 5 : int'(v[7:4]);
      su = (int'(v[3:0])   > 9) ? 9 : int'(v[3:0]);
      m  = mt * 10 + mu;
      if (m > MAXM) return MAXM * 60 + 59;
      return m * 60 + st * 10 + su;
   endfunction

   function automatic logic [27:0] hex_of(input logic [15:0] v);
      return {seg(int'(v[15:12])), seg(int'(v[11:8])), seg(int'(v[7:4])), seg(int'(v[3:0]))};
   endfunction

   // Reference model: time as whole seconds, state 0=idle 1=run 2=pause 3=done.
   int          m_state = 0, m_secs = 0, m_pre = 0, m_lapv = 0;
   bit          m_dir = 1'b0, m_wrap = 1'b0, m_hold = 1'b0;
   logic [15:0] m_disp = '0;

   always @(posedge clock) begin
      cyc++;
      if (reset_n) begin : model_step
         bit          st, cl, lp;
         int          old_state, old_secs;
         logic [15:0] old_disp;
         obs_t        o;
         st = (start_q.size() > 0) && (start_q[0] == cyc);
         if (st) void'(start_q.pop_front());
         cl = (clear_q.size() > 0) && (clear_q[0] == cyc);
         if (cl) void'(clear_q.pop_front());
         lp = (lap_q.size() > 0) && (lap_q[0] == cyc);
         if (lp) void'(lap_q.pop_front());
         old_state = m_state;
         old_secs  = m_secs;
         old_disp  = m_disp;
         m_wrap    = 1'b0;
         if (cl) begin
            m_state = 0; m_secs = 0; m_pre = 0;
         end else if (load && m_state != 1) begin
            m_secs = clamp_secs(preset_bcd);
            if (m_state == 3) m_state = 0;
         end else if (st) begin
            case (m_state)
               0: if (!(mode_down && m_secs == 0)) begin
                     m_state = 1; m_dir = mode_down; m_pre = 0;
                  end
               1: m_state = 2;
               2: m_state = 1;
               default: ;
            endcase
         end else if (m_state == 1) begin
            if (m_pre == DIV - 1) begin
               m_pre = 0;
               if (m_dir) begin
                  if (m_secs > 0) m_secs--;
                  if (m_secs == 0) m_state = 3;
               end else if (m_secs == MAXM * 60 + 59) begin
                  m_secs = 0;
                  m_wrap = 1'b1;
               end else begin
                  m_secs++;
               end
            end else begin
               m_pre++;
            end
         end
         if (old_state != 1) m_hold = 1'b0;
         else if (LAP_EN && lp) begin
            m_hold = !m_hold;
            m_lapv = old_secs;
         end
         m_disp = to_bcd(m_hold ? m_lapv : m_secs);
         o = {m_disp, hex_of(old_disp), m_state == 1, m_state == 3, m_wrap};
         if (o !== m_prev) begin
            sb.push_back('{cyc, o});
            m_prev = o;
         end
      end
   end

   // Monitor: every change of the DUT's visible outputs pops one expected event.
   always @(negedge clock) begin
      if (mon_en) begin : mon
         obs_t a;
         ev_t  e;
         a = {time_bcd, hex3, hex2, hex1, hex0, running, expired, wrap};
         if (a !== d_prev) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d got=%h", cyc, a);
            end else begin
               e = sb.pop_front();
               if (e.cyc != cyc || e.o !== a) begin
                  errors++;
                  $display("FAIL event cyc=%0d/%0d time=%h/%h hex=%h/%h run=%b/%b exp=%b/%b wrap=%b/%b (got/want)",
                           cyc, e.cyc, a.t, e.o.t, a.hex, e.o.hex, a.run, e.o.run,
                           a.exp, e.o.exp, a.wr, e.o.wr);
               end
            end
            d_prev = a;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // mask: bit0 start, bit1 clear, bit2 lap. Optional load lands on the press edge.
   task automatic press(input logic [2:0] mask, input bit with_load, input logic [15:0] val);
      if (mask[0]) begin start_key_n = 1'b0; start_q.push_back(cyc + LAT); end
      if (mask[1]) begin clear_key_n = 1'b0; clear_q.push_back(cyc + LAT); end
      if (mask[2]) begin lap_key_n   = 1'b0; lap_q.push_back(cyc + LAT);   end
      step(LAT - 1);
      if (with_load) begin preset_bcd = val; load = 1'b1; end
      step(1);
      load = 1'b0;
      step(1);
      start_key_n = 1'b1; clear_key_n = 1'b1; lap_key_n = 1'b1;
      step(LAT + 1);
   endtask

   task automatic glitch();
      start_key_n = 1'b0;
      step(1);
      start_key_n = 1'b1;
      step(LAT + 1);
   endtask

   task automatic do_load(input logic [15:0] val);
      preset_bcd = val;
      load = 1'b1;
      step(1);
      load = 1'b0;
   endtask

   function automatic logic [15:0] rand_preset();
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v[15:8] = '0;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      m_prev = {16'h0000, hex_of(16'h0000), 3'b000};
      d_prev = m_prev;
      repeat (3) @(negedge clock);
      chk("rst_time", time_bcd, 32'h0);
      chk("rst_hex", {hex3, hex2, hex1, hex0}, {4{7'h40}});
      chk("rst_flags", {running, expired, wrap}, 32'h0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      step(1);

      // Up count to 01:00
      press(3'b001, 1'b0, '0);
      step(235);
      chk("up_time", time_bcd, 32'h0100);
      chk("up_hex1", hex1, 32'h40);
      chk("up_hex2", hex2, 32'h79);
      press(3'b001, 1'b0, '0);
      press(3'b010, 1'b0, '0);

      // Wrap from MAX_MIN:59
      do_load(16'h5958);
      press(3'b001, 1'b0, '0);
      step(1);
      chk("wrap_hi", {wrap, running}, 32'h3);
      chk("wrap_time", time_bcd, 32'h0000);
      step(1);
      chk("wrap_lo", wrap, 32'h0);
      press(3'b010, 1'b0, '0);

      // Countdown to expiry; start ignored in DONE
      mode_down = 1'b1;
      do_load(16'h0002);
      press(3'b001, 1'b0, '0);
      step(2);
      chk("cd_expired", {expired, running}, 32'h2);
      chk("cd_time", time_bcd, 32'h0000);
      press(3'b001, 1'b0, '0);
      press(3'b001, 1'b0, '0);
      chk("done_hold", expired, 32'h1);
      press(3'b010, 1'b0, '0);
      press(3'b001, 1'b0, '0);     // down mode at 00:00 stays idle
      mode_down = 1'b0;

      // Glitch, pause, resume
      press(3'b001, 1'b0, '0);
      step(6);
      glitch();
      press(3'b001, 1'b0, '0);
      step(7);
      press(3'b001, 1'b0, '0);
      step(9);

      // Clamp and priority
      press(3'b001, 1'b0, '0);
      do_load(16'hAF7C);
      step(2);
      chk("clamp", time_bcd, 32'h5959);
      press(3'b011, 1'b0, '0);
      chk("clr_start", {time_bcd, running}, 32'h0);
      press(3'b001, 1'b1, 16'h0130); // load wins over start in IDLE
      chk("load_over_start", {time_bcd, running}, {16'h0130, 1'b0});

      // Randomized traffic
      for (int i = 0; i < 90; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: press(3'b001, 1'b0, '0);
            3:       press(3'b010, 1'b0, '0);
            4:       glitch();
            5: begin
               mode_down = 1'($urandom_range(0, 1));
               do_load(rand_preset());
            end
            6:       press(3'b001, 1'b1, rand_preset());
            7:       press(3'b100, 1'b0, '0);
            8:       press(3'b011, 1'b0, '0);
            default: step($urandom_range(10, 120));
         endcase
         step($urandom_range(0, 8));
      end

      // Quiet period, then every expected event must have been seen
      press(3'b010, 1'b0, '0);
      step(10);
      chk("sb_drain", sb.size(), 32'h0);

      // Asynchronous reset in the middle of a count
      mon_en = 1'b0;
      do_load(16'h0245);
      press(3'b001, 1'b0, '0);
      step(9);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_time", time_bcd, 32'h0);
      chk("async_rst_hex", {hex3, hex2, hex1, hex0}, {4{7'h40}});
      chk("async_rst_flags", {running, expired, wrap}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
